bus_to_sample: RTL and testbench

//  Playback counterpart of the sample packer. Accepts 64-bit words of 8 packed 8-bit samples
//  (byte 0 = bits [7:0], oldest) via valid/ready and replays them one byte per sample tick.

---
 rtl/b2s_pkg.sv | 23 ++
 rtl/bus_to_sample_if.sv | 12 +
 rtl/sample_tick_gen.sv | 28 ++
 rtl/bus_to_sample.sv | 104 ++++++++++
 tb/tb_bus_to_sample.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/b2s_pkg.sv
// Shared word/sample geometry, FSM state type and byte-select helper for the
// bus_to_sample playback path.
package b2s_pkg;

    localparam int SAMPLES_PER_WORD = 8;
    localparam int SAMPLE_W         = 8;
    localparam int WORD_W           = 64;
    localparam int IDX_W            = $clog2(SAMPLES_PER_WORD);

    typedef enum logic {
        B2S_IDLE,
        B2S_PLAY
    } b2s_state_t;

    // Byte 0 sits in the low bits and is the oldest sample in the word.
    function automatic logic [SAMPLE_W-1:0] word_byte(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        return word[idx*SAMPLE_W +: SAMPLE_W];
    endfunction

endpackage

// File: rtl/bus_to_sample_if.sv
// Word handshake between the processing side (master) and the playback block (slave).
interface bus_to_sample_if;
    import b2s_pkg::*;

    logic [WORD_W-1:0] bus_in;
    logic              set;
    logic              ready;

    modport master (output bus_in, output set, input ready);
    modport slave  (input bus_in, input set, output ready);

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate clock enable: one-cycle tick every TICK_DIV clocks.
// Shared with the sample packer so both sides agree on the sample rate.
module sample_tick_gen #(
    parameter int TICK_DIV = 5000
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/bus_to_sample.sv
// Replays 64-bit packed words one byte per sample tick, with a one-word holding buffer.
// Optional feature macro B2S_UNDERRUN_CNT_EN adds the saturating underrun_cnt port.
module bus_to_sample
    import b2s_pkg::*;
#(
    parameter int TICK_DIV = 5000
`ifdef B2S_UNDERRUN_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                clk_50mhz,
    input  logic                rst_n,
    bus_to_sample_if.slave      bus,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                underrun
`ifdef B2S_UNDERRUN_CNT_EN
    ,
    output logic [CNT_W-1:0]    underrun_cnt
`endif
);

    logic              tick;
    logic [WORD_W-1:0] hold_buf;
    logic              hold_full;
    logic [WORD_W-1:0] shift;
    logic [IDX_W-1:0]  idx;
    b2s_state_t        state;
    logic              underrun_now;

    sample_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .tick      (tick)
    );

    assign bus.ready    = ~hold_full;
    assign underrun_now = (state == B2S_IDLE) && tick;

    // Accept and hold->shift transfer are mutually exclusive: a transfer needs
    // hold_full, which already forces ready low, so their hold_full writes never collide.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            hold_buf     <= '0;
            hold_full    <= 1'b0;
            shift        <= '0;
            idx          <= '0;
            state        <= B2S_IDLE;
            sample       <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            underrun     <= underrun_now;

            if (bus.set && !hold_full) begin
                hold_buf  <= bus.bus_in;
                hold_full <= 1'b1;
            end

            case (state)
                B2S_IDLE: begin
                    if (hold_full) begin
                        shift     <= hold_buf;
                        idx       <= '0;
                        hold_full <= 1'b0;
                        state     <= B2S_PLAY;
                    end
                end
                B2S_PLAY: begin
                    if (tick) begin
                        sample       <= word_byte(shift, idx);
                        sample_valid <= 1'b1;
                        idx          <= idx + IDX_W'(1);
                        if (idx == IDX_W'(SAMPLES_PER_WORD - 1)) begin
                            if (hold_full) begin
                                shift     <= hold_buf;
                                idx       <= '0;
                                hold_full <= 1'b0;
                            end else begin
                                state <= B2S_IDLE;
                            end
                        end
                    end
                end
                default: state <= B2S_IDLE;
            endcase
        end
    end

`ifdef B2S_UNDERRUN_CNT_EN
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun_now && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bus_to_sample.sv
// Directed self-checking bench for bus_to_sample with TICK_DIV=4.
// Build with B2S_UNDERRUN_CNT_EN to also check the underrun counter and its saturation.
module tb_bus_to_sample;
    import b2s_pkg::*;

    localparam int TICK_DIV = 4;
    localparam logic [63:0] WORD_A = 64'h0706050403020100;
    localparam logic [63:0] WORD_B = 64'hFFEEDDCCBBAA9988;
    localparam logic [63:0] WORD_J = 64'h5A5A5A5A5A5A5A5A;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] sample;
    logic       sample_valid;
    logic       underrun;

    bus_to_sample_if bus_if ();

`ifdef B2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    logic [7:0]  sat_sample;
    logic        sat_valid;
    logic        sat_underrun;
    logic [1:0]  sat_cnt;

    bus_to_sample_if sat_if ();

    bus_to_sample #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (2)
    ) u_sat (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .bus          (sat_if.slave),
        .sample       (sat_sample),
        .sample_valid (sat_valid),
        .underrun     (sat_underrun),
        .underrun_cnt (sat_cnt)
    );
`endif

    bus_to_sample #(
        .TICK_DIV (TICK_DIV)
`ifdef B2S_UNDERRUN_CNT_EN
        ,
        .CNT_W    (16)
`endif
    ) dut (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .bus          (bus_if.slave),
        .sample       (sample),
        .sample_valid (sample_valid),
        .underrun     (underrun)
`ifdef B2S_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk_50mhz = ~clk_50mhz;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    logic [7:0] vq[$];
    int         vc[$];
    int         uc[$];

    // Advances n clocks, logging valid samples and underrun pulses at each falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_50mhz);
            cyc++;
            if (sample_valid) begin
                vq.push_back(sample);
                vc.push_back(cyc);
            end
            if (underrun) uc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        vq.delete();
        vc.delete();
        uc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run_cycles(3);
        checks++;
        if (sample !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_sample: got %0h expected 00", sample);
        end
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", sample_valid);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_underrun: got %0b expected 0", underrun);
        end
        checks++;
        if (bus_if.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %0b expected 1", bus_if.ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_no_data();
        clear_log();
        run_cycles(20);
        checks++;
        if (uc.size() != 5) begin
            errors++;
            $display("[TB] FAIL no_data_underruns: got %0d expected 5", uc.size());
        end
        checks++;
        if (vq.size() != 0) begin
            errors++;
            $display("[TB] FAIL no_data_valids: got %0d expected 0", vq.size());
        end
        checks++;
        if (sample !== 8'h00) begin
            errors++;
            $display("[TB] FAIL no_data_sample: got %0h expected 00", sample);
        end
`ifdef B2S_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL underrun_cnt: got %0d expected 5", underrun_cnt);
        end
        checks++;
        if (sat_cnt !== 2'd3) begin
            errors++;
            $display("[TB] FAIL underrun_cnt_sat: got %0d expected 3", sat_cnt);
        end
`endif
    endtask

    task automatic test_single_word();
        int last_v;
        int first_u;
        int mid_u;
        clear_log();
        bus_if.bus_in = WORD_A;
        bus_if.set    = 1'b1;
        run_cycles(1);
        bus_if.set = 1'b0;
        checks++;
        if (bus_if.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready_low: got %0b expected 0", bus_if.ready);
        end
        run_cycles(1);
        checks++;
        if (bus_if.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_ready_high: got %0b expected 1", bus_if.ready);
        end
        run_cycles(38);
        checks++;
        if (vq.size() != 8) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d expected 8", vq.size());
        end
        for (int k = 0; k < 8 && k < vq.size(); k++) begin
            checks++;
            if (vq[k] !== 8'(k)) begin
                errors++;
                $display("[TB] FAIL single_byte%0d: got %0h expected %0h", k, vq[k], 8'(k));
            end
        end
        checks++;
        if (vc.size() == 0 || vc[0] != 4) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d expected 4", (vc.size() == 0) ? -1 : vc[0]);
        end
        last_v  = (vc.size() == 0) ? 0 : vc[vc.size() - 1];
        first_u = -1;
        mid_u   = 0;
        foreach (uc[i]) begin
            if (first_u < 0 && uc[i] > last_v) first_u = uc[i];
            if (vc.size() != 0 && uc[i] > vc[0] && uc[i] < last_v) mid_u++;
        end
        checks++;
        if (first_u != last_v + TICK_DIV) begin
            errors++;
            $display("[TB] FAIL single_underrun_after: got %0d expected %0d", first_u, last_v + TICK_DIV);
        end
        checks++;
        if (mid_u != 0) begin
            errors++;
            $display("[TB] FAIL single_underrun_during: got %0d expected 0", mid_u);
        end
        checks++;
        if (sample !== 8'h07) begin
            errors++;
            $display("[TB] FAIL single_hold_sample: got %0h expected 07", sample);
        end
    endtask

    task automatic test_tick_period();
        for (int k = 0; k + 1 < vc.size(); k++) begin
            checks++;
            if (vc[k + 1] - vc[k] != TICK_DIV) begin
                errors++;
                $display("[TB] FAIL tick_period%0d: got %0d expected %0d", k, vc[k + 1] - vc[k], TICK_DIV);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         took;
        int         bad_gaps;
        int         last_v;
        int         first_u;
        logic [7:0] exp_b;
        clear_log();
        bus_if.bus_in = WORD_A;
        bus_if.set    = 1'b1;
        run_cycles(1);
        bus_if.bus_in = WORD_B;
        took = 1'b0;
        for (int i = 0; i < 10 && !took; i++) begin
            if (bus_if.ready === 1'b1) took = 1'b1;
            run_cycles(1);
        end
        checks++;
        if (!took) begin
            errors++;
            $display("[TB] FAIL b2b_accept_timeout: got no ready expected ready within 10 cycles");
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("[TB] FAIL b2b_accept_cycle: got %0d expected 3", cyc);
        end
        bus_if.bus_in = WORD_J;
        run_cycles(10);
        checks++;
        if (bus_if.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_ready: got %0b expected 0", bus_if.ready);
        end
        bus_if.set = 1'b0;
        run_cycles(60);
        checks++;
        if (vq.size() != 16) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 16", vq.size());
        end
        for (int k = 0; k < 16 && k < vq.size(); k++) begin
            exp_b = (k < 8) ? 8'(k) : 8'(8'h88 + 8'h11 * (k - 8));
            checks++;
            if (vq[k] !== exp_b) begin
                errors++;
                $display("[TB] FAIL b2b_byte%0d: got %0h expected %0h", k, vq[k], exp_b);
            end
        end
        bad_gaps = 0;
        for (int k = 0; k + 1 < vc.size(); k++) if (vc[k + 1] - vc[k] != TICK_DIV) bad_gaps++;
        checks++;
        if (bad_gaps != 0) begin
            errors++;
            $display("[TB] FAIL b2b_gapless: got %0d bad gaps expected 0", bad_gaps);
        end
        checks++;
        if (vc.size() < 9 || vc[8] != 36) begin
            errors++;
            $display("[TB] FAIL b2b_junction: got %0d expected 36", (vc.size() < 9) ? -1 : vc[8]);
        end
        last_v  = (vc.size() == 0) ? 0 : vc[vc.size() - 1];
        first_u = -1;
        foreach (uc[i]) if (first_u < 0 && uc[i] > last_v) first_u = uc[i];
        checks++;
        if (first_u != 68) begin
            errors++;
            $display("[TB] FAIL b2b_underrun_after: got %0d expected 68", first_u);
        end
        checks++;
        if (bus_if.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready_end: got %0b expected 1", bus_if.ready);
        end
    endtask

    task automatic test_reset_midplay();
        clear_log();
        bus_if.bus_in = WORD_A;
        bus_if.set    = 1'b1;
        run_cycles(1);
        bus_if.set = 1'b0;
        run_cycles(13);
        checks++;
        if (vq.size() != 3) begin
            errors++;
            $display("[TB] FAIL midplay_count: got %0d expected 3", vq.size());
        end
        rst_n = 1'b0;
        run_cycles(3);
        checks++;
        if (sample !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midplay_reset_sample: got %0h expected 00", sample);
        end
        checks++;
        if (bus_if.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midplay_reset_ready: got %0b expected 1", bus_if.ready);
        end
        rst_n = 1'b1;
        clear_log();
        run_cycles(24);
        checks++;
        if (vq.size() != 0) begin
            errors++;
            $display("[TB] FAIL midplay_partial_output: got %0d expected 0", vq.size());
        end
        checks++;
        if (uc.size() != 6) begin
            errors++;
            $display("[TB] FAIL midplay_underruns: got %0d expected 6", uc.size());
        end
        checks++;
        if (sample !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midplay_sample_after: got %0h expected 00", sample);
        end
`ifdef B2S_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL midplay_underrun_cnt: got %0d expected 6", underrun_cnt);
        end
`endif
    endtask

    initial begin
        bus_if.bus_in = '0;
        bus_if.set    = 1'b0;
`ifdef B2S_UNDERRUN_CNT_EN
        sat_if.bus_in = '0;
        sat_if.set    = 1'b0;
`endif
        $display("[TB] bus_to_sample bench, TICK_DIV=%0d", TICK_DIV);
        test_reset();
        test_no_data();
        test_single_word();
        test_tick_period();
        test_back_to_back();
        test_reset_midplay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
